// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage directly upstream of the instruction ROM.
// Owns the program counter (a word index), presents it to the ROM, and
// captures the combinationally returned word into an IF/ID register tagged
// with its PC and a valid bit. Supports stall, redirect with flush, and a
// HALT state entered when the PC runs past the end of the loaded program.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   pc_o           word index to instruction memory
//   instr_i        instruction word read combinationally at pc_o
//   stall_i        hold PC, IF/ID register and fetch count
//   redirect_i     taken branch/jump; loads redirect_pc_i and flushes IF/ID
//   redirect_pc_i  redirect target word index
//   if_id_valid_o  IF/ID register holds a live instruction
//   if_id_instr_o  latched instruction, bit-exact
//   if_id_pc_o     PC the latched instruction was fetched from
//   halted_o       high while in HALT
//   fetch_count_o  instructions latched since reset, saturating
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_LIMIT = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] pc_o,
  input  logic [31:0]         instr_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                if_id_valid_o,
  output logic [31:0]         if_id_instr_o,
  output logic [PC_WIDTH-1:0] if_id_pc_o,
  output logic                halted_o,
  output logic [15:0]         fetch_count_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Widen both sides so PC_LIMIT values beyond the PC range compare correctly
  // (in that case the limit is unreachable and the PC simply wraps).
  function automatic logic past_end(input logic [PC_WIDTH-1:0] p);
    return 64'(p) >= 64'(PC_LIMIT);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_p0, pc_d;
  logic                vld_p1, vld_d;
  logic [31:0]         instr_p1, instr_d;
  logic [PC_WIDTH-1:0] ifpc_p1, ifpc_d;
  logic [15:0]         cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_p0;
    vld_d   = vld_p1;
    instr_d = instr_p1;
    ifpc_d  = ifpc_p1;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          vld_d = 1'b0;
          if (past_end(redirect_pc_i)) state_d = HALT;
        end else if (past_end(pc_p0)) begin
          vld_d   = 1'b0;
          state_d = HALT;
        end else if (!stall_i) begin
          instr_d = instr_i;
          ifpc_d  = pc_p0;
          vld_d   = 1'b1;
          pc_d    = pc_p0 + PC_WIDTH'(1);
          cnt_d   = sat_inc(cnt_q);
        end
      end
      HALT: begin
        // stall_i has no effect here; only a redirect can move the PC.
        vld_d = 1'b0;
        if (redirect_i) begin
          pc_d = redirect_pc_i;
          if (!past_end(redirect_pc_i)) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC (stage 0) -> IF/ID register (stage 1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_p0    <= PC_WIDTH'(RESET_PC);
      vld_p1   <= 1'b0;
      instr_p1 <= 32'h0;
      ifpc_p1  <= '0;
      cnt_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_d;
      vld_p1   <= vld_d;
      instr_p1 <= instr_d;
      ifpc_p1  <= ifpc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_o          = pc_p0;
  assign if_id_valid_o = vld_p1;
  assign if_id_instr_o = instr_p1;
  assign if_id_pc_o    = ifpc_p1;
  assign halted_o      = (state_q == HALT);
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int unsigned LIMIT = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_o;
  logic [31:0] instr_i;
  logic        stall_i, redirect_i;
  logic [15:0] redirect_pc_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [15:0] if_id_pc_o;
  logic        halted_o;
  logic [15:0] fetch_count_o;

  // Narrow instance used only for the PC wrap check.
  logic        rst4_n;
  logic [3:0]  pc4, ifpc4;
  logic [31:0] instr4, ifinstr4;
  logic        vld4, halted4;
  logic [15:0] cnt4;

  int checks = 0;
  int failures = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    if (a == 16'd0) return 32'h00000293;
    if (a == 16'd1) return 32'h00000393;
    return 32'hA5000013 ^ ({16'h0, a} << 12);
  endfunction

  assign instr_i = rom(pc_o);
  assign instr4  = {28'h0, pc4};

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(0), .PC_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .instr_i(instr_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_id_valid_o(if_id_valid_o), .if_id_instr_o(if_id_instr_o),
    .if_id_pc_o(if_id_pc_o), .halted_o(halted_o), .fetch_count_o(fetch_count_o)
  );

  fetch_unit #(.PC_WIDTH(4), .RESET_PC(0), .PC_LIMIT(16)) u_wrap (
    .clk(clk), .rst_n(rst4_n), .pc_o(pc4), .instr_i(instr4),
    .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(4'd0),
    .if_id_valid_o(vld4), .if_id_instr_o(ifinstr4),
    .if_id_pc_o(ifpc4), .halted_o(halted4), .fetch_count_o(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must show after each edge.
  bit          m_boot, m_halt, m_valid;
  logic [15:0] m_pc, m_ifpc, m_cnt;
  logic [31:0] m_instr;

  task automatic model_edge();
    if (!rst_n) begin
      m_boot = 1; m_halt = 0; m_valid = 0;
      m_pc = 0; m_ifpc = 0; m_cnt = 0; m_instr = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_valid = 0;
      if (redirect_i) begin
        m_pc = redirect_pc_i;
        m_halt = (redirect_pc_i >= LIMIT);
      end
    end else if (redirect_i) begin
      m_pc = redirect_pc_i;
      m_valid = 0;
      m_halt = (redirect_pc_i >= LIMIT);
    end else if (m_pc >= LIMIT) begin
      m_halt = 1;
      m_valid = 0;
    end else if (!stall_i) begin
      m_ifpc = m_pc;
      m_instr = rom(m_pc);
      m_valid = 1;
      m_pc = m_pc + 16'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("pc", 32'(pc_o), 32'(m_pc));
      chk("valid", 32'(if_id_valid_o), 32'(m_valid));
      chk("halted", 32'(halted_o), 32'(m_halt));
      chk("count", 32'(fetch_count_o), 32'(m_cnt));
      chk("if_id_pc", 32'(if_id_pc_o), 32'(m_ifpc));
      chk("if_id_instr", if_id_instr_o, m_instr);
    end
  end

  // Drive one edge's inputs just after a falling edge, return at the next one.
  task automatic step(input logic s, input logic r, input logic [15:0] rp, input logic rn);
    #1;
    stall_i = s; redirect_i = r; redirect_pc_i = rp; rst_n = rn;
    @(negedge clk);
  endtask

  task automatic run_to_pc(input logic [15:0] target);
    for (int i = 0; i < 40; i++) begin
      if (pc_o == target) return;
      step(0, 0, 0, 1);
    end
    chk("wait_pc_timeout", 32'(pc_o), 32'(target));
  endtask

  initial begin
    logic [15:0] last_pc;
    bit got_halt;
    rst_n = 0; rst4_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    @(negedge clk);
    @(negedge clk);
    armed = 1;
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_valid", 32'(if_id_valid_o), 32'd0);
    chk("rst_count", 32'(fetch_count_o), 32'd0);

    // Reset and stream
    step(0, 0, 0, 1);
    chk("boot_valid", 32'(if_id_valid_o), 32'd0);
    step(0, 0, 0, 1);
    chk("first_pc", 32'(if_id_pc_o), 32'd0);
    chk("first_instr", if_id_instr_o, 32'h00000293);
    chk("first_valid", 32'(if_id_valid_o), 32'd1);
    step(0, 0, 0, 1);
    chk("second_pc", 32'(if_id_pc_o), 32'd1);
    chk("second_instr", if_id_instr_o, 32'h00000393);
    chk("count_two", 32'(fetch_count_o), 32'd2);

    // Stall at pc 5
    run_to_pc(16'd5);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1);
      chk("stall_pc", 32'(pc_o), 32'd5);
      chk("stall_ifpc", 32'(if_id_pc_o), 32'd4);
      chk("stall_count", 32'(fetch_count_o), 32'd5);
    end
    step(0, 0, 0, 1);
    chk("resume_ifpc", 32'(if_id_pc_o), 32'd5);
    chk("resume_pc", 32'(pc_o), 32'd6);

    // Redirect beats stall
    run_to_pc(16'd13);
    step(1, 1, 16'd2, 1);
    chk("redir_pc", 32'(pc_o), 32'd2);
    chk("redir_flush", 32'(if_id_valid_o), 32'd0);
    step(0, 0, 0, 1);
    chk("redir_ifpc", 32'(if_id_pc_o), 32'd2);
    chk("redir_valid", 32'(if_id_valid_o), 32'd1);

    // Halt after a fresh run from 0
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    last_pc = 16'hFFFF;
    got_halt = 0;
    for (int i = 0; i < 40 && !got_halt; i++) begin
      step(0, 0, 0, 1);
      if (if_id_valid_o) last_pc = if_id_pc_o;
      got_halt = halted_o;
    end
    chk("halt_reached", 32'(got_halt), 32'd1);
    chk("halt_last_ifpc", 32'(last_pc), 32'd27);
    chk("halt_pc", 32'(pc_o), 32'd28);
    for (int k = 0; k < 10; k++) begin
      step(k[0], 0, 0, 1);
      chk("halt_hold_pc", 32'(pc_o), 32'd28);
      chk("halt_hold_count", 32'(fetch_count_o), 32'd28);
      chk("halt_hold_flag", 32'(halted_o), 32'd1);
    end

    // Exit from HALT
    step(0, 1, 16'd30, 1);
    chk("exit1_halted", 32'(halted_o), 32'd1);
    chk("exit1_pc", 32'(pc_o), 32'd30);
    step(0, 1, 16'd0, 1);
    chk("exit2_halted", 32'(halted_o), 32'd0);
    chk("exit2_pc", 32'(pc_o), 32'd0);
    step(0, 0, 0, 1);
    chk("exit_ifpc", 32'(if_id_pc_o), 32'd0);
    chk("exit_valid", 32'(if_id_valid_o), 32'd1);
    chk("exit_instr", if_id_instr_o, 32'h00000293);

    // Reset during a redirect
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 16'd7, 0);
    chk("mrst_pc", 32'(pc_o), 32'd0);
    chk("mrst_valid", 32'(if_id_valid_o), 32'd0);
    chk("mrst_instr", if_id_instr_o, 32'h0);
    chk("mrst_ifpc", 32'(if_id_pc_o), 32'd0);
    chk("mrst_halted", 32'(halted_o), 32'd0);
    chk("mrst_count", 32'(fetch_count_o), 32'd0);
    step(0, 0, 0, 1);

    // Wrap on the 4-bit instance: BOOT, then pc 0,1,...,15,0,...
    rst4_n = 1;
    for (int j = 1; j <= 20; j++) begin
      step(0, 0, 0, 1);
      chk("wrap_pc", 32'(pc4), 32'((j - 1) % 16));
      chk("wrap_halted", 32'(halted4), 32'd0);
    end

    armed = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
